// File: rtl/spi_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_tx_arbiter                                                |
// | Purpose  : Frame-granular round-robin sharing of one SPI byte serializer  |
// |            with start/done handshake and a programmable inter-frame gap. |
// | Options  : SPI_ARB_TIMEOUT_EN adds a tx_done watchdog (err_timeout).     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module spi_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_err_timeout
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam bit c_HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [NUM_REQ-1:0]   r_grant;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [7:0]           r_tx_data;
  logic                 r_tx_start;
  logic                 r_last;
  logic                 r_busy;
  logic [c_GAP_W-1:0]   r_gap_cnt;

  logic [NUM_REQ-1:0]   w_mask;
  logic [NUM_REQ-1:0]   w_pick;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [c_PTR_W-1:0]   w_win_idx;
  logic [7:0]           w_gbyte;
  logic                 w_gvalid;
  logic                 w_glast;
  logic                 w_xfer;
  logic                 w_to_hit;

  // Requesters strictly above the pointer win first; otherwise wrap to the lowest.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (c_PTR_W'(i) > r_ptr);
    end
  end

  always_comb begin
    w_pick    = (|(i_req_valid & w_mask)) ? (i_req_valid & w_mask) : i_req_valid;
    w_win_idx = '0;
    w_win_oh  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        w_win_idx   = c_PTR_W'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_gbyte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_gbyte = i_req_data[8*i +: 8];
      end
    end
  end

  assign w_gvalid = |(i_req_valid & r_grant);
  assign w_glast  = |(i_req_last & r_grant);
  assign w_xfer   = (r_state == S_LOAD) && w_gvalid;

  always_comb begin
    o_req_ready = '0;
    if (r_state == S_LOAD) begin
      o_req_ready = i_req_valid & r_grant;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int c_TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_err;

  assign w_to_hit = (r_state == S_WAIT) && !i_tx_done && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err    <= w_to_hit;
      r_to_cnt <= ((r_state == S_WAIT) && (w_next == S_WAIT)) ? r_to_cnt + c_TO_W'(1) : '0;
    end
  end

  assign o_err_timeout = r_err;
`else
  assign w_to_hit = 1'b0;
  // TIMEOUT only has meaning when the watchdog is built in; this is constant 0.
  assign o_err_timeout = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (|i_req_valid) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (r_last) begin
            w_next = c_HAS_GAP ? S_GAP : S_IDLE;
          end else begin
            w_next = S_LOAD;
          end
        end else if (w_to_hit) begin
          w_next = c_HAS_GAP ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= '0;
      r_ptr      <= c_PTR_W'(NUM_REQ - 1);
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_gap_cnt  <= '0;
    end else begin
      r_tx_start <= w_xfer;
      r_busy     <= (w_next != S_IDLE);
      r_gap_cnt  <= (r_state == S_GAP) ? r_gap_cnt + c_GAP_W'(1) : '0;
      if (w_xfer) begin
        r_tx_data <= w_gbyte;
        r_last    <= w_glast;
      end
      // Ownership is taken in IDLE and dropped on the edge that returns to IDLE.
      if (r_state == S_IDLE) begin
        if (|i_req_valid) begin
          r_grant <= w_win_oh;
          r_ptr   <= w_win_idx;
        end
      end else if (w_next == S_IDLE) begin
        r_grant <= '0;
      end
    end
  end

  assign o_grant    = r_grant;
  assign o_busy     = r_busy;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_tx_arbiter                                             |
// | Purpose  : Directed self-checking bench for spi_tx_arbiter.              |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spi_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_last;
  logic [3:0]  o_req_ready;
  logic [3:0]  o_grant;
  logic        o_busy;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_err_timeout;

  int checks = 0;
  int errors = 0;

  spi_tx_arbiter #(
    .NUM_REQ    (4),
    .GAP_CYCLES (2),
    .TIMEOUT    (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (i_req_valid),
    .i_req_data    (i_req_data),
    .i_req_last    (i_req_last),
    .o_req_ready   (o_req_ready),
    .o_grant       (o_grant),
    .o_busy        (o_busy),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .i_tx_done     (i_tx_done),
    .o_err_timeout (o_err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        done;
    logic [3:0]  rdy;
    logic [3:0]  grant;
    logic        busy;
    logic        start;
    logic [7:0]  txd;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input bit nonzero, input int budget);
    int n = 0;
    while (((o_grant != 4'b0) != nonzero) && n < budget) begin
      step();
      n++;
    end
    if ((o_grant != 4'b0) != nonzero) begin
      checks++;
      errors++;
      $display("FAIL wait_grant: got grant %0h after %0d cycles, required nonzero=%0d", o_grant, n, nonzero);
    end
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!o_tx_start && n < budget) begin
      step();
      n++;
    end
    if (!o_tx_start) begin
      checks++;
      errors++;
      $display("FAIL wait_start: got no tx_start within %0d cycles, required one", budget);
    end
  endtask

  task automatic pulse_done();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    i_tx_done   = 1'b0;
    step();
    step();
    chk("rst_grant", {28'b0, o_grant}, 32'h0);
    chk("rst_busy", {31'b0, o_busy}, 32'h0);
    chk("rst_start", {31'b0, o_tx_start}, 32'h0);
    chk("rst_txd", {24'b0, o_tx_data}, 32'h0);
    chk("rst_err", {31'b0, o_err_timeout}, 32'h0);
    chk("rst_ready", {28'b0, o_req_ready}, 32'h0);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // valid, data, last, done | ready, grant, busy, start, tx_data
    tbl.push_back(vec_t'{4'h1, 32'h0000_00A5, 4'h0, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 8'h00});
    tbl.push_back(vec_t'{4'h1, 32'h0000_00A5, 4'h0, 1'b0, 4'h1, 4'h1, 1'b1, 1'b1, 8'hA5});
    for (int i = 0; i < 4; i++)
      tbl.push_back(vec_t'{4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{4'h0, 32'h0, 4'h0, 1'b1, 4'h0, 4'h1, 1'b1, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{4'h1, 32'h0000_003C, 4'h1, 1'b0, 4'h1, 4'h1, 1'b1, 1'b1, 8'h3C});
    for (int i = 0; i < 4; i++)
      tbl.push_back(vec_t'{4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 8'h3C});
    tbl.push_back(vec_t'{4'h0, 32'h0, 4'h0, 1'b1, 4'h0, 4'h1, 1'b1, 1'b0, 8'h3C});
    tbl.push_back(vec_t'{4'h4, 32'h0011_0000, 4'h4, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 8'h3C});
    tbl.push_back(vec_t'{4'h4, 32'h0011_0000, 4'h4, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h3C});
    tbl.push_back(vec_t'{4'h4, 32'h0011_0000, 4'h4, 1'b0, 4'h0, 4'h4, 1'b1, 1'b0, 8'h3C});
    tbl.push_back(vec_t'{4'h0, 32'h0, 4'h0, 1'b1, 4'h0, 4'h4, 1'b1, 1'b0, 8'h3C});
    tbl.push_back(vec_t'{4'h4, 32'h0011_0000, 4'h4, 1'b0, 4'h4, 4'h4, 1'b1, 1'b1, 8'h11});
    tbl.push_back(vec_t'{4'h0, 32'h0, 4'h0, 1'b1, 4'h0, 4'h4, 1'b1, 1'b0, 8'h11});
    tbl.push_back(vec_t'{4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h4, 1'b1, 1'b0, 8'h11});
    tbl.push_back(vec_t'{4'h0, 32'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 8'h11});
    tbl.push_back(vec_t'{4'h0, 32'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 8'h11});

    apply_reset();

    foreach (tbl[k]) begin
      i_req_valid = tbl[k].valid;
      i_req_data  = tbl[k].data;
      i_req_last  = tbl[k].last;
      i_tx_done   = tbl[k].done;
      #1;
      chk($sformatf("tbl[%0d] ready", k), {28'b0, o_req_ready}, {28'b0, tbl[k].rdy});
      step();
      chk($sformatf("tbl[%0d] grant", k), {28'b0, o_grant}, {28'b0, tbl[k].grant});
      chk($sformatf("tbl[%0d] busy", k), {31'b0, o_busy}, {31'b0, tbl[k].busy});
      chk($sformatf("tbl[%0d] start", k), {31'b0, o_tx_start}, {31'b0, tbl[k].start});
      chk($sformatf("tbl[%0d] txd", k), {24'b0, o_tx_data}, {24'b0, tbl[k].txd});
      chk($sformatf("tbl[%0d] err", k), {31'b0, o_err_timeout}, 32'h0);
    end
    i_tx_done = 1'b0;

    // Round-robin: all four stay valid with single-byte frames.
    apply_reset();
    i_req_valid = 4'hF;
    i_req_last  = 4'hF;
    i_req_data  = 32'hC3C2_C1C0;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] exp_g;
      logic [7:0] exp_d;
      exp_g = 4'b0001 << (k % 4);
      exp_d = 8'hC0 + 8'(k % 4);
      wait_grant(1'b1, 20);
      chk($sformatf("rr[%0d] grant", k), {28'b0, o_grant}, {28'b0, exp_g});
      wait_start(10);
      chk($sformatf("rr[%0d] txd", k), {24'b0, o_tx_data}, {24'b0, exp_d});
      pulse_done();
      wait_grant(1'b0, 10);
    end
    i_req_valid = 4'h0;

    // Stall: req1 drops valid mid-frame while req2 waits.
    apply_reset();
    i_req_valid = 4'b0110;
    i_req_data  = 32'h00D2_B100;
    i_req_last  = 4'b0100;
    wait_grant(1'b1, 20);
    chk("stall grant0", {28'b0, o_grant}, 32'h2);
    wait_start(10);
    chk("stall byte0", {24'b0, o_tx_data}, 32'hB1);
    i_req_valid = 4'b0100;
    pulse_done();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall hold[%0d] grant", i), {28'b0, o_grant}, 32'h2);
      chk($sformatf("stall hold[%0d] start", i), {31'b0, o_tx_start}, 32'h0);
      step();
    end
    i_req_valid = 4'b0110;
    i_req_data  = 32'h00D2_B200;
    i_req_last  = 4'b0110;
    wait_start(10);
    chk("stall byte1", {24'b0, o_tx_data}, 32'hB2);
    pulse_done();
    wait_grant(1'b0, 10);
    wait_grant(1'b1, 10);
    chk("stall next grant", {28'b0, o_grant}, 32'h4);
    wait_start(10);
    chk("stall req2 byte", {24'b0, o_tx_data}, 32'hD2);
    i_req_valid = 4'h0;
    pulse_done();
    wait_grant(1'b0, 10);

    // Reset during WAIT_DONE of byte 2 of a 4-byte frame.
    apply_reset();
    i_req_valid = 4'b0001;
    i_req_data  = 32'h0000_0001;
    i_req_last  = 4'b0000;
    wait_grant(1'b1, 20);
    wait_start(10);
    chk("mid byte1", {24'b0, o_tx_data}, 32'h01);
    i_req_data = 32'h0000_0002;
    pulse_done();
    wait_start(10);
    chk("mid byte2", {24'b0, o_tx_data}, 32'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst grant", {28'b0, o_grant}, 32'h0);
    chk("mid rst busy", {31'b0, o_busy}, 32'h0);
    chk("mid rst start", {31'b0, o_tx_start}, 32'h0);
    chk("mid rst txd", {24'b0, o_tx_data}, 32'h0);
    chk("mid rst ready", {28'b0, o_req_ready}, 32'h0);
    step();
    step();
    rst_n       = 1'b1;
    i_req_valid = 4'b1001;
    i_req_data  = 32'h6600_0055;
    i_req_last  = 4'b1001;
    wait_grant(1'b1, 20);
    chk("mid post grant", {28'b0, o_grant}, 32'h1);
    wait_start(10);
    chk("mid post txd", {24'b0, o_tx_data}, 32'h55);
    i_req_valid = 4'h0;
    pulse_done();
    wait_grant(1'b0, 10);

`ifdef SPI_ARB_TIMEOUT_EN
    apply_reset();
    i_req_valid = 4'b0011;
    i_req_data  = 32'h0000_BBAA;
    i_req_last  = 4'b0011;
    wait_grant(1'b1, 20);
    chk("to grant0", {28'b0, o_grant}, 32'h1);
    wait_start(10);
    chk("to txd0", {24'b0, o_tx_data}, 32'hAA);
    begin
      int n = 0;
      while (!o_err_timeout && n < 100) begin
        step();
        n++;
      end
      chk("to delay", n, 32'd64);
    end
    step();
    chk("to pulse width", {31'b0, o_err_timeout}, 32'h0);
    wait_grant(1'b0, 10);
    wait_grant(1'b1, 10);
    chk("to next grant", {28'b0, o_grant}, 32'h2);
    wait_start(10);
    chk("to next txd", {24'b0, o_tx_data}, 32'hBB);
    i_req_valid = 4'h0;
    pulse_done();
    wait_grant(1'b0, 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares one SPI byte serializer among NUM_REQ hash-table requesters.
- Round-robin arbitration at frame granularity: a granted requester owns the link until it sends its byte flagged last.
- Sequences the serializer byte by byte with a start/done handshake.
- Enforces a programmable idle gap between frames.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles between frames; 0 means no gap state.
- TIMEOUT, 64, cycles to wait for tx_done before aborting; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte on its data slice.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- req_last  in  NUM_REQ  byte from requester i is the final byte of its frame.
- req_ready  out  NUM_REQ  combinational; byte accepted on this rising edge.
- grant  out  NUM_REQ  registered one-hot owner of the link; 0 when idle.
- busy  out  1  registered; high whenever state is not IDLE.
- tx_data  out  8  registered byte to the serializer.
- tx_start  out  1  registered one-cycle pulse; tx_data is valid with it.
- tx_done  in  1  serializer finished the current byte; one-cycle pulse.
- err_timeout  out  1  one-cycle pulse on abort; tied 0 without the feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; grant, busy, tx_data, tx_start and err_timeout all 0.
  - RR pointer set so that requester 0 has highest priority next.
  - last_flag and gap counter cleared.
- IDLE:
  - If any req_valid, pick the first set bit searching upward (with wrap) from pointer+1.
  - Register grant = one-hot(winner); set pointer = winner; go to LOAD.
  - req_ready stays 0 in IDLE.
- LOAD:
  - req_ready[g] = req_valid[g] & grant[g]; all other req_ready bits are 0.
  - On a transfer edge: tx_data <= byte, tx_start <= 1 for the next cycle, last_flag <= req_last[g], go to WAIT_DONE.
  - If req_valid[g] is 0, stay in LOAD with grant held; other requesters are not served mid-frame.
- WAIT_DONE:
  - tx_start is high only in the first cycle of this state.
  - On tx_done: if last_flag, go to GAP (or IDLE with grant cleared when GAP_CYCLES=0); otherwise go to LOAD.
- GAP:
  - Count GAP_CYCLES cycles, clear grant, then go to IDLE.
  - req_valid is ignored in GAP.
- Latency:
  - req_valid rising at cycle N in IDLE gives grant at N+1.
  - Transfer at the end of N+1; tx_start high at N+2.
  - Minimum spacing between bytes in one frame: tx_done cycle plus 1 (LOAD).
- Boundary conditions:
  - tx_done outside WAIT_DONE is ignored.
  - tx_done in the same cycle as tx_start is accepted.
  - A single-byte frame (req_last=1 on the first byte) is legal.
  - A fair requester that stays valid is served again only after every other valid requester has had one frame.
  - Reset mid-frame aborts immediately. No partial-frame state survives; the serializer sees no further tx_start.
  - NUM_REQ=1 degenerates to frame pacing only, with no arbitration.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE.
  - If TIMEOUT cycles elapse without tx_done: err_timeout pulses for 1 cycle, the remaining frame is abandoned, and the block goes to GAP.
  - The abandoned requester's later bytes are treated as a new frame when it is next granted.
- Undefined:
  - No counter; WAIT_DONE waits indefinitely.
  - err_timeout is constant 0.

Test Plan:
- Single frame: req0 sends A5,3C (last on 3C), tx_done returned 4 cycles after each tx_start -> tx_data shows A5 then 3C; exactly two tx_start pulses; grant=0001 until GAP ends; busy falls after 2 gap cycles.
- Round-robin: req0..req3 all valid, each sending a 1-byte frame, repeated twice -> grant order 0,1,2,3,0,1,2,3; no requester is served twice in a row.
- Stall mid-frame: req1 drops valid for 10 cycles between bytes while req2 is valid -> grant stays 0010; req2 is served only after req1's last byte.
- Spurious done: tx_done pulsed in IDLE and in LOAD -> no state change, no extra tx_start.
- Reset mid-frame: rst low during WAIT_DONE of byte 2 of 4 -> all outputs 0 immediately; after release, req0 is granted first if valid.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT=64): tx_done withheld -> err_timeout pulses 64 cycles after tx_start, GAP then IDLE, next requester is granted.
